// File: rtl/song_player.sv
// Melody player: walks a note ROM from a start address and drives a square-wave beep.
// Each ROM word selects pitch (octave/degree) and duration in beats; an end marker stops or loops.
module song_player #(
    parameter int CLK_HZ   = 5_000_000,
    parameter int BEAT_HZ  = 4,
    parameter int GAP_CLKS = 50_000,
    parameter int ADDR_W   = 7,
    parameter int DIV_W    = 16
) (
    input  logic              clk_5MHz,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop,
    input  logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [11:0]       rom_data,
    output logic              beep,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] LOAD  = 2'd2;
    localparam logic [1:0] PLAY  = 2'd3;

    localparam int BEAT_CLKS = CLK_HZ / BEAT_HZ;
    localparam int PRESC_W   = $clog2(BEAT_CLKS);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(BEAT_CLKS - 1);
    localparam logic [PRESC_W-1:0] GAP_START  = PRESC_W'(BEAT_CLKS - GAP_CLKS);

    // Entry 0 stands in for the rest degree so the table covers every 3-bit code.
    localparam int DEGREE_HZ [8] = '{262, 262, 294, 330, 349, 392, 440, 494};

    logic [DIV_W-1:0] hp_mid [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_pitch
            assign hp_mid[gi] = DIV_W'(CLK_HZ / (2 * DEGREE_HZ[gi]));
        end
    endgenerate

    logic             word_end;
    logic [1:0]       word_oct;
    logic [2:0]       word_deg;
    logic [5:0]       word_dur;
    logic             word_rest;
    logic [DIV_W-1:0] word_hp;

    assign word_end  = rom_data[11];
    assign word_oct  = rom_data[10:9];
    assign word_deg  = rom_data[8:6];
    assign word_dur  = rom_data[5:0];
    assign word_rest = (word_oct == 2'd0) || (word_deg == 3'd0);

    always_comb begin
        case (word_oct)
            2'd1:    word_hp = hp_mid[word_deg] << 1;
            2'd3:    word_hp = hp_mid[word_deg] >> 1;
            default: word_hp = hp_mid[word_deg];
        endcase
    end

    logic [1:0]         state_reg, state_next;
    logic [ADDR_W-1:0]  base_reg, base_next;
    logic [ADDR_W-1:0]  rom_addr_reg, rom_addr_next;
    logic [DIV_W-1:0]   hp_reg, hp_next;
    logic [DIV_W-1:0]   tone_cnt_reg, tone_cnt_next;
    logic [PRESC_W-1:0] presc_reg, presc_next;
    logic [5:0]         beats_reg, beats_next;
    logic               tone_reg, tone_next;
    logic               rest_reg, rest_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;

    always_comb begin
        state_next    = state_reg;
        base_next     = base_reg;
        rom_addr_next = rom_addr_reg;
        hp_next       = hp_reg;
        tone_cnt_next = tone_cnt_reg;
        presc_next    = presc_reg;
        beats_next    = beats_reg;
        tone_next     = tone_reg;
        rest_next     = rest_reg;
        done_next     = 1'b0;

        if (stop) begin
            state_next = IDLE;
        end else if (start) begin
            // An end marker reached in the same cycle still reports completion.
            if (state_reg == LOAD && word_end && !loop)
                done_next = 1'b1;
            base_next     = start_addr;
            rom_addr_next = start_addr;
            state_next    = FETCH;
        end else begin
            case (state_reg)
                IDLE: ;
                FETCH: state_next = LOAD;
                LOAD: begin
                    if (word_end) begin
                        if (loop) begin
                            rom_addr_next = base_reg;
                            state_next    = FETCH;
                        end else begin
                            done_next  = 1'b1;
                            state_next = IDLE;
                        end
                    end else begin
                        hp_next       = word_hp;
                        rest_next     = word_rest;
                        beats_next    = word_dur;
                        tone_cnt_next = '0;
                        presc_next    = '0;
                        tone_next     = 1'b0;
                        state_next    = PLAY;
                    end
                end
                PLAY: begin
                    if (!pause) begin
                        if (tone_cnt_reg == hp_reg - DIV_W'(1)) begin
                            tone_cnt_next = '0;
                            tone_next     = ~tone_reg;
                        end else begin
                            tone_cnt_next = tone_cnt_reg + DIV_W'(1);
                        end
                        if (presc_reg == PRESC_LAST) begin
                            presc_next = '0;
                            if (beats_reg == 6'd0) begin
                                rom_addr_next = rom_addr_reg + ADDR_W'(1);
                                state_next    = FETCH;
                            end else begin
                                beats_next = beats_reg - 6'd1;
                            end
                        end else begin
                            presc_next = presc_reg + PRESC_W'(1);
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        busy_next = (state_next != IDLE) || done_next;
    end

    always_ff @(posedge clk_5MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            base_reg     <= '0;
            rom_addr_reg <= '0;
            hp_reg       <= '0;
            tone_cnt_reg <= '0;
            presc_reg    <= '0;
            beats_reg    <= '0;
            tone_reg     <= 1'b0;
            rest_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            base_reg     <= base_next;
            rom_addr_reg <= rom_addr_next;
            hp_reg       <= hp_next;
            tone_cnt_reg <= tone_cnt_next;
            presc_reg    <= presc_next;
            beats_reg    <= beats_next;
            tone_reg     <= tone_next;
            rest_reg     <= rest_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    // Articulation gap: the tail of the final beat of every note is silent.
    logic gap;
    assign gap = (beats_reg == 6'd0) && (presc_reg >= GAP_START);

    assign beep     = (state_reg == PLAY) && !rest_reg && !pause && !gap && tone_reg;
    assign rom_addr = rom_addr_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_song_player.sv
// Bench for song_player: note-level reference model checked every cycle, plus timed directed scenarios.
`timescale 1ns/1ps
module tb_song_player;

    localparam int CLK_HZ  = 5_000_000;
    localparam int BEAT_HZ = 1000;
    localparam int GAP     = 500;
    localparam int BC      = CLK_HZ / BEAT_HZ;

    logic        clk_5MHz = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        pause = 1'b0;
    logic        loop = 1'b0;
    logic [6:0]  start_addr = '0;
    logic [6:0]  rom_addr;
    logic [11:0] rom_data;
    logic        beep, busy, done;

    logic [11:0] rom [128];

    int n_checks = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    song_player #(
        .CLK_HZ(CLK_HZ), .BEAT_HZ(BEAT_HZ), .GAP_CLKS(GAP), .ADDR_W(7), .DIV_W(16)
    ) dut (
        .clk_5MHz(clk_5MHz), .rst_n(rst_n), .start(start), .stop(stop),
        .pause(pause), .loop(loop), .start_addr(start_addr), .rom_addr(rom_addr),
        .rom_data(rom_data), .beep(beep), .busy(busy), .done(done)
    );

    always #100 clk_5MHz = ~clk_5MHz;

    always @(posedge clk_5MHz) rom_data <= rom[rom_addr];

    // ---------------- reference model (note-level) ----------------
    int         m_phase = 0;   // 0 idle, 1 fetch, 2 load, 3 play
    logic [6:0] m_addr = '0;
    logic [6:0] m_base = '0;
    int         m_k = 0;       // clocks of the current note already played
    int         m_len = 1;     // total clocks of the current note
    int         m_hp = 1;
    logic       m_rest = 1'b0;
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;

    function automatic int model_hp(input int oct, input int deg);
        int f, mid;
        case (deg)
            1: f = 262;  2: f = 294;  3: f = 330;  4: f = 349;
            5: f = 392;  6: f = 440;  7: f = 494;
            default: f = 262;
        endcase
        mid = CLK_HZ / (2 * f);
        if (oct == 1) return 2 * mid;
        if (oct == 3) return mid / 2;
        return mid;
    endfunction

    function automatic logic exp_beep();
        if (m_phase != 3 || m_rest || pause) return 1'b0;
        if (m_k >= m_len - GAP) return 1'b0;
        return ((m_k / m_hp) % 2) == 1;
    endfunction

    task automatic model_step();
        logic [11:0] w;
        logic nd;
        nd = 1'b0;
        w = rom[m_addr];
        if (stop) begin
            m_phase = 0;
        end else if (start) begin
            if (m_phase == 2 && w[11] && !loop) nd = 1'b1;
            m_base = start_addr;
            m_addr = start_addr;
            m_phase = 1;
        end else begin
            case (m_phase)
                1: m_phase = 2;
                2: begin
                    if (w[11]) begin
                        if (loop) begin
                            m_addr = m_base;
                            m_phase = 1;
                        end else begin
                            nd = 1'b1;
                            m_phase = 0;
                        end
                    end else begin
                        m_len  = (int'(w[5:0]) + 1) * BC;
                        m_hp   = model_hp(int'(w[10:9]), int'(w[8:6]));
                        m_rest = (w[10:9] == 2'd0) || (w[8:6] == 3'd0);
                        m_k    = 0;
                        m_phase = 3;
                    end
                end
                3: begin
                    if (!pause) begin
                        if (m_k == m_len - 1) begin
                            m_addr = m_addr + 7'd1;
                            m_phase = 1;
                        end else begin
                            m_k = m_k + 1;
                        end
                    end
                end
                default: ;
            endcase
        end
        m_done = nd;
        m_busy = (m_phase != 0) || nd;
    endtask

    task automatic model_reset();
        m_phase = 0; m_addr = '0; m_base = '0; m_k = 0;
        m_busy = 1'b0; m_done = 1'b0; m_rest = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk_5MHz or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [9:0] cmp_exp, cmp_act;
    initial begin
        forever begin
            @(negedge clk_5MHz);
            if (chk_en) begin
                cmp_exp = {exp_beep(), m_busy, m_done, m_addr};
                cmp_act = {beep, busy, done, rom_addr};
                n_checks++;
                if (cmp_act !== cmp_exp) begin
                    n_fail++;
                    $display("FAIL cycle_compare t=%0t beep/busy/done/addr got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                             $time, cmp_act[9], cmp_act[8], cmp_act[7], cmp_act[6:0],
                             cmp_exp[9], cmp_exp[8], cmp_exp[7], cmp_exp[6:0]);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk_5MHz);
        #1;
    endtask

    task automatic pulse_start(input logic [6:0] a);
        start_addr = a;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Cycle 1 is the first cycle after the start pulse is sampled.
    task automatic run_measure(input int max_cyc, output int rise, output int dn);
        rise = -1;
        dn = -1;
        for (int n = 1; n <= max_cyc; n++) begin
            @(negedge clk_5MHz);
            if (beep && rise < 0) rise = n;
            if (done) begin
                dn = n;
                break;
            end
        end
    endtask

    function automatic logic [11:0] mkw(input logic e, input logic [1:0] o,
                                        input logic [2:0] d, input logic [5:0] u);
        return {e, o, d, u};
    endfunction

    int r, d, cnt, rises, first_rise, second_rise, wrap_at;
    logic prev_beep;

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = 12'h000;
        rom[0]   = mkw(1'b0, 2'd3, 3'd6, 6'd0);  // high A, 1 beat
        rom[1]   = mkw(1'b1, 2'd0, 3'd0, 6'd0);  // end
        rom[20]  = mkw(1'b0, 2'd3, 3'd1, 6'd1);  // high C, 2 beats
        rom[21]  = mkw(1'b0, 2'd0, 3'd0, 6'd0);  // rest, 1 beat
        rom[22]  = mkw(1'b1, 2'd0, 3'd0, 6'd0);  // end
        rom[40]  = mkw(1'b0, 2'd3, 3'd1, 6'd1);  // high C, 2 beats
        rom[41]  = mkw(1'b1, 2'd0, 3'd0, 6'd0);  // end
        rom[127] = mkw(1'b0, 2'd3, 3'd5, 6'd0);  // high G, 1 beat

        // Pitch table anchors
        check("hp_mid_A", model_hp(2, 6), 5681);
        check("hp_high_C", model_hp(3, 1), 4770);
        check("hp_low_C", model_hp(1, 1), 19082);
        check("hp_high_A", model_hp(3, 6), 2840);

        #50;
        check("reset_beep", int'(beep), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_addr", int'(rom_addr), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        chk_en = 1'b1;
        repeat (5) tick();

        // T1: single high A note
        pulse_start(7'd0);
        run_measure(20000, r, d);
        $display("T1 single note: first rise cycle %0d, done cycle %0d", r, d);
        check("t1_first_rise", r, 2843);
        check("t1_done_cycle", d, 5005);
        check("t1_busy_at_done", int'(busy), 1);
        @(negedge clk_5MHz);
        check("t1_busy_after", int'(busy), 0);

        // T2: note + rest + end, no loop
        repeat (10) tick();
        pulse_start(7'd20);
        run_measure(40000, r, d);
        $display("T2 note+rest: first rise cycle %0d, done cycle %0d", r, d);
        check("t2_first_rise", r, 4773);
        check("t2_done_cycle", d, 15007);

        // T3: same song looped
        repeat (10) tick();
        loop = 1'b1;
        pulse_start(7'd20);
        cnt = 0; rises = 0; first_rise = -1; second_rise = -1; prev_beep = 1'b0;
        for (int n = 1; n <= 31000; n++) begin
            @(negedge clk_5MHz);
            if (done) cnt++;
            if (beep && !prev_beep) begin
                rises++;
                if (first_rise < 0) first_rise = n;
                else if (second_rise < 0) second_rise = n;
            end
            prev_beep = beep;
        end
        $display("T3 loop: rises %0d at %0d and %0d, done pulses %0d", rises, first_rise, second_rise, cnt);
        check("t3_done_pulses", cnt, 0);
        check("t3_rises", rises, 2);
        check("t3_period", second_rise - first_rise, 15006);
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        loop = 1'b0;
        @(negedge clk_5MHz);
        check("t3_busy_after_stop", int'(busy), 0);

        // T4: pause mid-note for 1000 clocks
        repeat (10) tick();
        pulse_start(7'd40);
        repeat (4999) tick();
        @(negedge clk_5MHz);
        check("t4_beep_before_pause", int'(beep), 1);
        tick();
        pause = 1'b1;
        @(negedge clk_5MHz);
        check("t4_beep_paused", int'(beep), 0);
        repeat (1000) tick();
        pause = 1'b0;
        run_measure(20000, r, d);
        $display("T4 pause: done %0d cycles after resume", d);
        check("t4_done_after_resume", d, 5005);

        // T5: address wrap, restart while busy, simultaneous stop+start
        repeat (10) tick();
        pulse_start(7'd127);
        wrap_at = -1;
        for (int n = 1; n <= 6000; n++) begin
            @(negedge clk_5MHz);
            if (rom_addr == 7'd0) begin
                wrap_at = n;
                break;
            end
        end
        $display("T5 wrap: rom_addr reached 0 at cycle %0d", wrap_at);
        check("t5_wrap_cycle", wrap_at, 5003);
        repeat (10) tick();
        pulse_start(7'd40);
        repeat (100) tick();
        start_addr = 7'd20;
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        @(negedge clk_5MHz);
        check("t5_busy_stop_start", int'(busy), 0);
        check("t5_beep_stop_start", int'(beep), 0);
        cnt = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk_5MHz);
            if (done || busy) cnt++;
        end
        check("t5_stays_idle", cnt, 0);

        // T6: asynchronous reset mid-note
        pulse_start(7'd0);
        repeat (3000) tick();
        #20;
        check("t6_beep_before_reset", int'(beep), 1);
        rst_n = 1'b0;
        #1;
        check("t6_beep_async", int'(beep), 0);
        check("t6_busy_async", int'(busy), 0);
        check("t6_done_async", int'(done), 0);
        check("t6_addr_async", int'(rom_addr), 0);
        repeat (5) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        @(negedge clk_5MHz);
        check("t6_idle_busy", int'(busy), 0);
        check("t6_idle_addr", int'(rom_addr), 0);
        $display("T6 reset: idle after release, busy %0d", busy);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
